// File: rtl/instr_seq_fsm_pkg.sv
// Shared encodings for the MSP430 fetch/execute sequencer and instruction-length decode.
// Contents: sequencer state encodings, instruction format codes, register indices,
// As addressing-mode codes, the single-operand opcode list, the decode result struct,
// and small helper functions.
package instr_seq_fsm_pkg;

    localparam int unsigned IR_W = 16;

    // Sequencer states; the encoding is visible on seq_state
    typedef enum logic [2:0] {
        SEQ_FETCH   = 3'd0,
        SEQ_SRC_EXT = 3'd1,
        SEQ_DST_EXT = 3'd2,
        SEQ_EXEC    = 3'd3,
        SEQ_WAIT    = 3'd4,
        SEQ_ERR     = 3'd5,
        SEQ_TRAP    = 3'd6
    } seq_state_e;

    // Instruction formats as seen by the length decoder
    typedef enum logic [1:0] {
        FMT_I   = 2'd0,
        FMT_II  = 2'd1,
        FMT_J   = 2'd2,
        FMT_ILL = 2'd3
    } fmt_e;

    // Single-operand (format II) opcodes in IR[9:7]; 3'b111 is undefined
    typedef enum logic [2:0] {
        OP_RRC  = 3'd0,
        OP_SWPB = 3'd1,
        OP_RRA  = 3'd2,
        OP_SXT  = 3'd3,
        OP_PUSH = 3'd4,
        OP_CALL = 3'd5,
        OP_RETI = 3'd6
    } fmtii_op_e;

    localparam logic [5:0] FMTII_PREFIX = 6'b000100;  // IR[15:10]
    localparam logic [2:0] FMTJ_PREFIX  = 3'b001;     // IR[15:13]

    localparam logic [3:0] REG_R0 = 4'd0;   // PC: @PC+ is immediate
    localparam logic [3:0] REG_R3 = 4'd3;   // constant generator for every As

    localparam logic [1:0] AS_INDEXED   = 2'b01;
    localparam logic [1:0] AS_INDIR_INC = 2'b11;

    // Decode result: which extension words follow, and whether the word is undefined
    typedef struct packed {
        logic src_ext;
        logic dst_ext;
        logic illegal;
    } len_dec_t;

    function automatic logic fmtii_defined(input logic [2:0] op);
        case (fmtii_op_e'(op))
            OP_RRC, OP_SWPB, OP_RRA, OP_SXT,
            OP_PUSH, OP_CALL, OP_RETI: fmtii_defined = 1'b1;
            default:                   fmtii_defined = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] instr_words(input len_dec_t d);
        instr_words = 2'd1 + 2'(d.src_ext) + 2'(d.dst_ext);
    endfunction

endpackage

// File: rtl/instr_seq_fsm_len_dec.sv
// Instruction-length decoder (instr_len_dec): combinational IR word -> {src_ext, dst_ext, illegal}.
// Shared with the instruction decoder so both agree on extension-word counts.
// Ports:
//   ir_i   in  16  instruction word (MDB_out during the fetch ack)
//   dec_o  out  3  len_dec_t {src_ext, dst_ext, illegal}
module instr_seq_fsm_len_dec
    import instr_seq_fsm_pkg::*;
(
    input  logic [IR_W-1:0] ir_i,
    output len_dec_t        dec_o
);

    fmt_e       fmt;
    logic [3:0] src_reg;
    logic [1:0] as_mode;
    logic       src_ext_mode;
    logic       unused_bw;

    // Format classification; IR[15:12] >= 4 is the two-operand space
    always_comb begin
        fmt = FMT_ILL;
        if (ir_i[15:14] != 2'b00) begin
            fmt = FMT_I;
        end else if (ir_i[15:13] == FMTJ_PREFIX) begin
            fmt = FMT_J;
        end else if ((ir_i[15:10] == FMTII_PREFIX) && fmtii_defined(ir_i[9:7])) begin
            fmt = FMT_II;
        end
    end

    assign src_reg = (fmt == FMT_II) ? ir_i[3:0] : ir_i[11:8];
    assign as_mode = ir_i[5:4];

    // Indexed/symbolic/absolute and immediate need a word; R3 and R2 As=10/11 are constants
    assign src_ext_mode = ((as_mode == AS_INDEXED)   && (src_reg != REG_R3)) ||
                          ((as_mode == AS_INDIR_INC) && (src_reg == REG_R0));

    // Byte/word select does not change the word count
    assign unused_bw = ir_i[6];

    // Undefined words decode as 1-word with no extensions
    always_comb begin
        dec_o         = '0;
        dec_o.src_ext = ((fmt == FMT_I) || (fmt == FMT_II)) && src_ext_mode;
        dec_o.dst_ext = (fmt == FMT_I) && ir_i[7];
        dec_o.illegal = (fmt == FMT_ILL);
    end

endmodule

// File: rtl/instr_seq_fsm.sv
// MSP430 fetch/execute sequencer: fetches the instruction word and its extension words,
// pulses PC increment and IR/extension loads, starts the function unit and waits for it.
// Optional feature: define ILLEGAL_TRAP_EN to trap undefined opcodes (TRAP state, sticky
// illegal flag). Without it undefined words run as 1-word NOPs and illegal stays 0.
// Ports:
//   clk         in   1  core clock
//   rst         in   1  synchronous active-high reset
//   MDB_out     in  16  memory data bus
//   mem_ack     in   1  read complete, MDB_out valid this cycle
//   CALC_done   in   1  function unit finished (sampled in WAIT only)
//   mem_req     out  1  read request at PC
//   IR_ld       out  1  latch MDB_out into IR (same cycle as mem_ack)
//   SRC_EXT_ld  out  1  latch MDB_out as source extension word
//   DST_EXT_ld  out  1  latch MDB_out as destination extension word
//   PC_inc      out  1  PC <= PC+2
//   exec_start  out  1  one-cycle execute strobe
//   instr_len   out  2  words in current instruction
//   seq_state   out  3  current state encoding
//   bus_err     out  1  sticky read-timeout flag
//   illegal     out  1  sticky illegal-opcode flag
module instr_seq_fsm
    import instr_seq_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] MDB_out,
    input  logic            mem_ack,
    input  logic            CALC_done,
    output logic            mem_req,
    output logic            IR_ld,
    output logic            SRC_EXT_ld,
    output logic            DST_EXT_ld,
    output logic            PC_inc,
    output logic            exec_start,
    output logic [1:0]      instr_len,
    output logic [2:0]      seq_state,
    output logic            bus_err,
    output logic            illegal
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    seq_state_e      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            dst_pend_q, dst_pend_d;
    logic [1:0]      instr_len_q, instr_len_d;
    logic            mem_req_q, mem_req_d;
    logic            exec_start_q, exec_start_d;
    logic            bus_err_q, bus_err_d;
    logic            illegal_q, illegal_d;
    logic            in_mem_state;
    logic            timeout_hit;
    len_dec_t        dec;

    instr_seq_fsm_len_dec u_len_dec (
        .ir_i  (MDB_out),
        .dec_o (dec)
    );

    assign in_mem_state = (state_q == SEQ_FETCH) || (state_q == SEQ_SRC_EXT) ||
                          (state_q == SEQ_DST_EXT);

    // Last allowed unacknowledged cycle; an ack in this cycle still wins
    assign timeout_hit = in_mem_state && !mem_ack && (to_cnt_q == TO_W'(TIMEOUT - 1));

    // State and registered-output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEQ_FETCH;
            to_cnt_q     <= '0;
            dst_pend_q   <= 1'b0;
            instr_len_q  <= 2'd1;
            mem_req_q    <= 1'b1;
            exec_start_q <= 1'b0;
            bus_err_q    <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            dst_pend_q   <= dst_pend_d;
            instr_len_q  <= instr_len_d;
            mem_req_q    <= mem_req_d;
            exec_start_q <= exec_start_d;
            bus_err_q    <= bus_err_d;
            illegal_q    <= illegal_d;
        end
    end

    // Next-state, timeout counter and per-instruction decode capture
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = '0;
        dst_pend_d  = dst_pend_q;
        instr_len_d = instr_len_q;

        // Every ack leaves its state, so clearing on ack also clears on entry
        if (in_mem_state && !mem_ack) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        case (state_q)
            SEQ_FETCH: begin
                if (mem_ack) begin
                    dst_pend_d  = dec.dst_ext;
                    instr_len_d = instr_words(dec);
                    if (TRAP_EN && dec.illegal) begin
                        state_d = SEQ_TRAP;
                    end else if (dec.src_ext) begin
                        state_d = SEQ_SRC_EXT;
                    end else if (dec.dst_ext) begin
                        state_d = SEQ_DST_EXT;
                    end else begin
                        state_d = SEQ_EXEC;
                    end
                end
            end
            SEQ_SRC_EXT: begin
                if (mem_ack) begin
                    state_d = dst_pend_q ? SEQ_DST_EXT : SEQ_EXEC;
                end
            end
            SEQ_DST_EXT: begin
                if (mem_ack) begin
                    state_d = SEQ_EXEC;
                end
            end
            SEQ_EXEC: state_d = SEQ_WAIT;
            SEQ_WAIT: begin
                if (CALC_done) begin
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_ERR:  state_d = SEQ_ERR;
            SEQ_TRAP: state_d = SEQ_TRAP;
            default:  state_d = SEQ_FETCH;
        endcase

        if (timeout_hit) begin
            state_d = SEQ_ERR;
        end
    end

    // Outputs: load/PC pulses coincide with the ack so MDB_out is valid with them
    always_comb begin
        IR_ld        = 1'b0;
        SRC_EXT_ld   = 1'b0;
        DST_EXT_ld   = 1'b0;
        PC_inc       = 1'b0;
        mem_req_d    = (state_d == SEQ_FETCH) || (state_d == SEQ_SRC_EXT) ||
                       (state_d == SEQ_DST_EXT);
        exec_start_d = (state_d == SEQ_EXEC);
        bus_err_d    = (state_d == SEQ_ERR);
        illegal_d    = (state_d == SEQ_TRAP);

        if (!rst && mem_ack) begin
            case (state_q)
                SEQ_FETCH: begin
                    IR_ld  = 1'b1;
                    PC_inc = 1'b1;
                end
                SEQ_SRC_EXT: begin
                    SRC_EXT_ld = 1'b1;
                    PC_inc     = 1'b1;
                end
                SEQ_DST_EXT: begin
                    DST_EXT_ld = 1'b1;
                    PC_inc     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign exec_start = exec_start_q;
    assign instr_len  = instr_len_q;
    assign seq_state  = state_q;
    assign bus_err    = bus_err_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_instr_seq_fsm.sv
// Scoreboard bench for instr_seq_fsm: the driver pushes expected load/exec events,
// a negedge monitor pops and compares whenever any pulse output is active.
module tb_instr_seq_fsm;

    localparam logic [3:0] K_IR   = 4'b0001;
    localparam logic [3:0] K_SRC  = 4'b0010;
    localparam logic [3:0] K_DST  = 4'b0100;
    localparam logic [3:0] K_EXEC = 4'b1000;

    typedef struct {
        logic [3:0]  kind;
        logic [15:0] data;
        logic        pc_inc;
        logic [1:0]  len;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] MDB_out = 16'h0;
    logic        mem_ack = 1'b0;
    logic        CALC_done = 1'b0;
    logic        mem_req, IR_ld, SRC_EXT_ld, DST_EXT_ld, PC_inc, exec_start;
    logic [1:0]  instr_len;
    logic [2:0]  seq_state;
    logic        bus_err, illegal;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [3:0] mon_act;
    ev_t        mon_ev;
    logic       mon_bad;

    instr_seq_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .MDB_out    (MDB_out),
        .mem_ack    (mem_ack),
        .CALC_done  (CALC_done),
        .mem_req    (mem_req),
        .IR_ld      (IR_ld),
        .SRC_EXT_ld (SRC_EXT_ld),
        .DST_EXT_ld (DST_EXT_ld),
        .PC_inc     (PC_inc),
        .exec_start (exec_start),
        .instr_len  (instr_len),
        .seq_state  (seq_state),
        .bus_err    (bus_err),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every active pulse cycle must match the next expected event
    always @(negedge clk) begin
        mon_act = {exec_start, DST_EXT_ld, SRC_EXT_ld, IR_ld};
        if ((mon_act != 4'b0000) || PC_inc) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d kind=%b pc_inc=%b", cyc, mon_act, PC_inc);
            end else begin
                mon_ev  = exp_q.pop_front();
                mon_bad = (mon_act !== mon_ev.kind) || (PC_inc !== mon_ev.pc_inc) ||
                          (cyc != mon_ev.cyc);
                if (mon_ev.kind == K_EXEC) mon_bad = mon_bad || (instr_len !== mon_ev.len);
                else                       mon_bad = mon_bad || (MDB_out !== mon_ev.data);
                if (mon_bad) begin
                    errors++;
                    $display("FAIL event cyc=%0d got kind=%b pc_inc=%b mdb=%h len=%0d; want cyc=%0d kind=%b pc_inc=%b mdb=%h len=%0d",
                             cyc, mon_act, PC_inc, MDB_out, instr_len,
                             mon_ev.cyc, mon_ev.kind, mon_ev.pc_inc, mon_ev.data, mon_ev.len);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [3:0] k, input logic [15:0] d, input logic pc,
                           input logic [1:0] len, input int c);
        ev_t e;
        e.kind = k; e.data = d; e.pc_inc = pc; e.len = len; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // One acknowledged read: load pulse and PC_inc expected in this very cycle
    task automatic ack_word(input logic [3:0] k, input logic [15:0] w);
        chk("mem_req_at_ack", int'(mem_req), 1);
        MDB_out = w;
        mem_ack = 1'b1;
        push_ev(k, w, 1'b1, 2'd0, cyc);
        step(1);
        mem_ack = 1'b0;
        MDB_out = 16'h0;
    endtask

    task automatic exec_phase(input logic [1:0] len, input bit early_done);
        chk("state_exec", int'(seq_state), 3);
        chk("mem_req_exec", int'(mem_req), 0);
        push_ev(K_EXEC, 16'h0, 1'b0, len, cyc);
        CALC_done = early_done;
        step(1);
        CALC_done = 1'b0;
        chk("state_wait", int'(seq_state), 4);
        chk("instr_len", int'(instr_len), int'(len));
        // A stray ack outside the fetch states must produce no pulse
        mem_ack = 1'b1;
        MDB_out = 16'hDEAD;
        step(1);
        mem_ack = 1'b0;
        MDB_out = 16'h0;
        chk("state_wait_hold", int'(seq_state), 4);
        CALC_done = 1'b1;
        step(1);
        CALC_done = 1'b0;
        chk("state_fetch_after_done", int'(seq_state), 0);
    endtask

    task automatic run_instr(input logic [15:0] w0, input logic [3:0] k1, input logic [15:0] w1,
                             input logic [3:0] k2, input logic [15:0] w2, input int nw,
                             input bit early_done);
        ack_word(K_IR, w0);
        if (nw > 1) ack_word(k1, w1);
        if (nw > 2) ack_word(k2, w2);
        exec_phase(2'(nw), early_done);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_state", int'(seq_state), 0);
        chk("rst_mem_req", int'(mem_req), 1);
        chk("rst_instr_len", int'(instr_len), 1);
        chk("rst_bus_err", int'(bus_err), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_exec_start", int'(exec_start), 0);

        // MOV R5,R6 with CALC_done already high in EXEC (must be ignored)
        run_instr(16'h4506, K_SRC, 16'h0, K_DST, 16'h0, 1, 1'b1);
        // MOV #0x1234,R6
        run_instr(16'h4036, K_SRC, 16'h1234, K_DST, 16'h0, 2, 1'b0);
        // MOV 2(R5),4(R6)
        run_instr(16'h4596, K_SRC, 16'h0002, K_DST, 16'h0004, 3, 1'b0);
        // MOV #1,R6 via R3 constant
        run_instr(16'h4316, K_SRC, 16'h0, K_DST, 16'h0, 1, 1'b0);
        // MOV &0x200,R6
        run_instr(16'h4216, K_SRC, 16'h0200, K_DST, 16'h0, 2, 1'b0);
        // MOV R5,2(R6): destination word only
        run_instr(16'h4586, K_DST, 16'h0002, K_DST, 16'h0, 2, 1'b0);
        // MOV #1,&0x200: R3 constant source, destination word
        run_instr(16'h4392, K_DST, 16'h0200, K_DST, 16'h0, 2, 1'b0);
        // MOV #4,R6 via R2 constant
        run_instr(16'h4226, K_SRC, 16'h0, K_DST, 16'h0, 1, 1'b0);
        // MOV @R5+,R6
        run_instr(16'h4536, K_SRC, 16'h0, K_DST, 16'h0, 1, 1'b0);
        // PUSH #0x5555
        run_instr(16'h1230, K_SRC, 16'h5555, K_DST, 16'h0, 2, 1'b0);
        // JC with As/Ad-looking bits set: jumps take no extension words
        run_instr(16'h2C90, K_SRC, 16'h0, K_DST, 16'h0, 1, 1'b0);

        // Ack withheld 15 cycles in SRC_EXT -> ERR
        ack_word(K_IR, 16'h4036);
        step(14);
        chk("to_state_before", int'(seq_state), 1);
        chk("to_bus_err_before", int'(bus_err), 0);
        step(1);
        chk("to_state_err", int'(seq_state), 5);
        chk("to_bus_err", int'(bus_err), 1);
        chk("to_mem_req", int'(mem_req), 0);
        mem_ack = 1'b1;
        MDB_out = 16'h1234;
        step(1);
        mem_ack = 1'b0;
        chk("err_sticky", int'(bus_err), 1);
        chk("err_state_hold", int'(seq_state), 5);
        do_reset();
        chk("err_rst_state", int'(seq_state), 0);
        chk("err_rst_bus_err", int'(bus_err), 0);
        chk("err_rst_mem_req", int'(mem_req), 1);

        // Ack on the 15th cycle wins over the timeout
        ack_word(K_IR, 16'h4036);
        step(14);
        ack_word(K_SRC, 16'h1234);
        chk("late_ack_no_err", int'(bus_err), 0);
        exec_phase(2'd2, 1'b0);

`ifdef ILLEGAL_TRAP_EN
        ack_word(K_IR, 16'h0000);
        chk("trap_state", int'(seq_state), 6);
        chk("trap_illegal", int'(illegal), 1);
        chk("trap_mem_req", int'(mem_req), 0);
        step(3);
        chk("trap_hold", int'(illegal), 1);
        do_reset();
        chk("trap_rst_illegal", int'(illegal), 0);
        ack_word(K_IR, 16'h1380);
        chk("trap_fmtii_state", int'(seq_state), 6);
        do_reset();
`else
        run_instr(16'h0000, K_SRC, 16'h0, K_DST, 16'h0, 1, 1'b0);
        chk("nop_illegal_0000", int'(illegal), 0);
        run_instr(16'h1380, K_SRC, 16'h0, K_DST, 16'h0, 1, 1'b0);
        chk("nop_illegal_1380", int'(illegal), 0);
`endif

        // rst in DST_EXT with an ack present: no load pulse, partial words discarded
        ack_word(K_IR, 16'h4596);
        ack_word(K_SRC, 16'h0002);
        chk("mid_state_dst", int'(seq_state), 2);
        rst = 1'b1;
        mem_ack = 1'b1;
        MDB_out = 16'h0004;
        step(1);
        rst = 1'b0;
        mem_ack = 1'b0;
        MDB_out = 16'h0;
        chk("mid_rst_state", int'(seq_state), 0);
        chk("mid_rst_len", int'(instr_len), 1);

        // rst asserted in WAIT -> FETCH next cycle
        ack_word(K_IR, 16'h4506);
        push_ev(K_EXEC, 16'h0, 1'b0, 2'd1, cyc);
        step(1);
        chk("wait_before_rst", int'(seq_state), 4);
        do_reset();
        chk("wait_rst_state", int'(seq_state), 0);
        chk("wait_rst_mem_req", int'(mem_req), 1);

        run_instr(16'h4036, K_SRC, 16'hBEEF, K_DST, 16'h0, 2, 1'b0);

        step(2);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
